// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bus: decoded ID-stage fields in, registered EX-stage fields out.
// The ID stage drives through master; the pipeline register itself connects as slave.
interface id_ex_reg_if #(
    parameter int CNT_W = 16
);
    logic             Enable_i;
    logic             Flush_i;
    logic             Ctrl_Sel_i;
    logic             RegWrite_i;
    logic             MemtoReg_i;
    logic             MemRead_i;
    logic             MemWrite_i;
    logic             ALUSrc_i;
    logic             RegDst_i;
    logic [1:0]       ALUOp_i;
    logic [31:0]      RSdata_i;
    logic [31:0]      RTdata_i;
    logic [31:0]      SignExt_i;
    logic [4:0]       Rs_i;
    logic [4:0]       Rt_i;
    logic [4:0]       Rd_i;

    logic             RegWrite_o;
    logic             MemtoReg_o;
    logic             MemRead_o;
    logic             MemWrite_o;
    logic             ALUSrc_o;
    logic             RegDst_o;
    logic [1:0]       ALUOp_o;
    logic [31:0]      RSdata_o;
    logic [31:0]      RTdata_o;
    logic [31:0]      SignExt_o;
    logic [4:0]       Rs_o;
    logic [4:0]       Rt_o;
    logic [4:0]       Rd_o;
    logic             Valid_o;
    logic [CNT_W-1:0] BubbleCnt_o;
    logic [CNT_W-1:0] FlushCnt_o;

    modport master (
        output Enable_i, Flush_i, Ctrl_Sel_i,
        output RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i, ALUOp_i,
        output RSdata_i, RTdata_i, SignExt_i, Rs_i, Rt_i, Rd_i,
        input  RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o, ALUOp_o,
        input  RSdata_o, RTdata_o, SignExt_o, Rs_o, Rt_o, Rd_o,
        input  Valid_o, BubbleCnt_o, FlushCnt_o
    );

    modport slave (
        input  Enable_i, Flush_i, Ctrl_Sel_i,
        input  RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i, RegDst_i, ALUOp_i,
        input  RSdata_i, RTdata_i, SignExt_i, Rs_i, Rt_i, Rd_i,
        output RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o, ALUSrc_o, RegDst_o, ALUOp_o,
        output RSdata_o, RTdata_o, SignExt_o, Rs_o, Rt_o, Rd_o,
        output Valid_o, BubbleCnt_o, FlushCnt_o
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with hold, flush and bubble insertion plus saturating
// bubble/flush statistics counters. Every output comes straight from a flop.
module id_ex_reg #(
    parameter int CNT_W = 16
) (
    input logic         clk_i,
    input logic         rst_i,
    id_ex_reg_if.slave  bus
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + CNT_W'(1);
    endfunction

    // Priority: reset, hold (Enable_i low), flush, bubble, load.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.RegWrite_o  <= 1'b0;
            bus.MemtoReg_o  <= 1'b0;
            bus.MemRead_o   <= 1'b0;
            bus.MemWrite_o  <= 1'b0;
            bus.ALUSrc_o    <= 1'b0;
            bus.RegDst_o    <= 1'b0;
            bus.ALUOp_o     <= 2'b00;
            bus.RSdata_o    <= 32'd0;
            bus.RTdata_o    <= 32'd0;
            bus.SignExt_o   <= 32'd0;
            bus.Rs_o        <= 5'd0;
            bus.Rt_o        <= 5'd0;
            bus.Rd_o        <= 5'd0;
            bus.Valid_o     <= 1'b0;
            bus.BubbleCnt_o <= '0;
            bus.FlushCnt_o  <= '0;
        end else if (bus.Enable_i) begin
            if (bus.Flush_i) begin
                bus.RegWrite_o <= 1'b0;
                bus.MemtoReg_o <= 1'b0;
                bus.MemRead_o  <= 1'b0;
                bus.MemWrite_o <= 1'b0;
                bus.ALUSrc_o   <= 1'b0;
                bus.RegDst_o   <= 1'b0;
                bus.ALUOp_o    <= 2'b00;
                bus.RSdata_o   <= 32'd0;
                bus.RTdata_o   <= 32'd0;
                bus.SignExt_o  <= 32'd0;
                bus.Rs_o       <= 5'd0;
                bus.Rt_o       <= 5'd0;
                bus.Rd_o       <= 5'd0;
                bus.Valid_o    <= 1'b0;
                bus.FlushCnt_o <= sat_inc(bus.FlushCnt_o);
            end else begin
                // Operands and specifiers are captured on both bubble and load; only control differs.
                bus.RSdata_o   <= bus.RSdata_i;
                bus.RTdata_o   <= bus.RTdata_i;
                bus.SignExt_o  <= bus.SignExt_i;
                bus.Rs_o       <= bus.Rs_i;
                bus.Rt_o       <= bus.Rt_i;
                bus.Rd_o       <= bus.Rd_i;
                if (!bus.Ctrl_Sel_i) begin
                    bus.RegWrite_o  <= 1'b0;
                    bus.MemtoReg_o  <= 1'b0;
                    bus.MemRead_o   <= 1'b0;
                    bus.MemWrite_o  <= 1'b0;
                    bus.ALUSrc_o    <= 1'b0;
                    bus.RegDst_o    <= 1'b0;
                    bus.ALUOp_o     <= 2'b00;
                    bus.Valid_o     <= 1'b0;
                    bus.BubbleCnt_o <= sat_inc(bus.BubbleCnt_o);
                end else begin
                    bus.RegWrite_o <= bus.RegWrite_i;
                    bus.MemtoReg_o <= bus.MemtoReg_i;
                    bus.MemRead_o  <= bus.MemRead_i;
                    bus.MemWrite_o <= bus.MemWrite_i;
                    bus.ALUSrc_o   <= bus.ALUSrc_i;
                    bus.RegDst_o   <= bus.RegDst_i;
                    bus.ALUOp_o    <= bus.ALUOp_i;
                    bus.Valid_o    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed vector table, multi-cycle corner sequences and a
// randomized run against a rule-level reference model.
module tb_id_ex_reg;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_ex_reg_if #(.CNT_W(CNT_W)) bus ();

    id_ex_reg #(.CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst, en, fl, cs;
        logic [7:0]  ctrl;
        logic [31:0] rsd;
        logic [4:0]  rt;
        logic [7:0]  e_ctrl;
        logic [31:0] e_rsd;
        logic [4:0]  e_rt;
        logic        e_vld;
        int          e_b, e_f;
    } vec_t;

    // Reference model state: unbounded event counts, saturation applied on compare.
    typedef struct {
        logic [7:0]  ctrl;
        logic [31:0] rsd, rtd, se;
        logic [4:0]  rs, rt, rd;
        logic        vld;
        int          nb, nf;
    } mdl_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctrl_out();
        return {bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o, bus.MemWrite_o,
                bus.ALUSrc_o, bus.RegDst_o, bus.ALUOp_o};
    endfunction

    // {RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, RegDst, ALUOp[1:0]}
    task automatic drive(input logic r, input logic en, input logic fl, input logic cs,
                         input logic [7:0] c, input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic [31:0] se, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd);
        rst            = r;
        bus.Enable_i   = en;
        bus.Flush_i    = fl;
        bus.Ctrl_Sel_i = cs;
        {bus.RegWrite_i, bus.MemtoReg_i, bus.MemRead_i, bus.MemWrite_i,
         bus.ALUSrc_i, bus.RegDst_i, bus.ALUOp_i} = c;
        bus.RSdata_i  = rsd;
        bus.RTdata_i  = rtd;
        bus.SignExt_i = se;
        bus.Rs_i      = rs;
        bus.Rt_i      = rt;
        bus.Rd_i      = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int n);
        return (n > CMAX) ? CMAX : n;
    endfunction

    vec_t tbl[13];
    mdl_t m;

    initial begin
        logic r, en, fl, cs;
        logic [7:0]  c;
        logic [31:0] rsd, rtd, se;
        logic [4:0]  rs, rt, rd;

        //          rst   en    fl    cs    ctrl   rsdata        rt     e_ctrl e_rsdata      e_rt   vld   b  f
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 32'hFFFF_FFFF, 5'd31, 8'h00, 32'h0,        5'd0,  1'b0, 0, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h82, 32'h1234_5678, 5'd9,  8'h82, 32'h1234_5678, 5'd9,  1'b1, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hE0, 32'hAAAA_0001, 5'd7,  8'hE0, 32'hAAAA_0001, 5'd7,  1'b1, 0, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 32'h0,         5'd3,  8'hE0, 32'hAAAA_0001, 5'd7,  1'b1, 0, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 32'h0,         5'd3,  8'hE0, 32'hAAAA_0001, 5'd7,  1'b1, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 32'h0,         5'd3,  8'hE0, 32'hAAAA_0001, 5'd7,  1'b1, 0, 0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 32'hDEAD_BEEF, 5'd3,  8'h00, 32'h0,        5'd0,  1'b0, 0, 1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hE0, 32'hAAAA_0001, 5'd7,  8'hE0, 32'hAAAA_0001, 5'd7,  1'b1, 0, 1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hE0, 32'hBBBB_0002, 5'd12, 8'h00, 32'hBBBB_0002, 5'd12, 1'b0, 1, 1};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hFF, 32'h5555_5555, 5'd4,  8'h00, 32'h0,        5'd0,  1'b0, 1, 2};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 32'h0000_0001, 5'd1,  8'h00, 32'h0000_0001, 5'd1,  1'b0, 2, 2};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 32'h7777_7777, 5'd8,  8'h00, 32'h0,        5'd0,  1'b0, 0, 0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h5D, 32'hCAFE_F00D, 5'd31, 8'h5D, 32'hCAFE_F00D, 5'd31, 1'b1, 0, 0};

        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].fl, tbl[i].cs, tbl[i].ctrl, tbl[i].rsd,
                  ~tbl[i].rsd, tbl[i].rsd ^ 32'h55, tbl[i].rt + 5'd1, tbl[i].rt, tbl[i].rt + 5'd2);
            tick();
            check($sformatf("vec%0d_ctrl", i),  64'(ctrl_out()),       64'(tbl[i].e_ctrl));
            check($sformatf("vec%0d_rsdata", i), 64'(bus.RSdata_o),    64'(tbl[i].e_rsd));
            check($sformatf("vec%0d_rt", i),    64'(bus.Rt_o),         64'(tbl[i].e_rt));
            check($sformatf("vec%0d_valid", i), 64'(bus.Valid_o),      64'(tbl[i].e_vld));
            check($sformatf("vec%0d_bcnt", i),  64'(bus.BubbleCnt_o),  64'(tbl[i].e_b));
            check($sformatf("vec%0d_fcnt", i),  64'(bus.FlushCnt_o),   64'(tbl[i].e_f));
        end

        // Bubble still captures the operand side: check the fields the table leaves implicit.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 32'h0102_0304, 32'h0A0B_0C0D, 32'hFFFF_FF80,
              5'd17, 5'd18, 5'd19);
        tick();
        check("bubble_rtdata", 64'(bus.RTdata_o),  64'h0A0B_0C0D);
        check("bubble_signext", 64'(bus.SignExt_o), 64'hFFFF_FF80);
        check("bubble_rs_rd", 64'({bus.Rs_o, bus.Rd_o}), 64'({5'd17, 5'd19}));
        check("bubble_memread", 64'(bus.MemRead_o), 64'h0);

        // Consecutive stalls: 20 bubble edges saturate the 4-bit counter and hold it there.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        for (int i = 1; i <= 20; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 32'(i), 32'h0, 32'h0, 5'd0, 5'(i), 5'd0);
            tick();
            check($sformatf("sat_bcnt%0d", i), 64'(bus.BubbleCnt_o), 64'(sat(i)));
            check($sformatf("sat_valid%0d", i), 64'(bus.Valid_o), 64'h0);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        check("sat_hold_bcnt", 64'(bus.BubbleCnt_o), 64'hF);

        // Randomized run against the reference model.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        tick();
        m = '{8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0};
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 39) == 0);
            en  = ($urandom_range(0, 4) != 0);
            fl  = ($urandom_range(0, 5) == 0);
            cs  = ($urandom_range(0, 3) != 0);
            c   = 8'($urandom);
            rsd = $urandom;
            rtd = $urandom;
            se  = $urandom;
            rs  = 5'($urandom);
            rt  = 5'($urandom);
            rd  = 5'($urandom);
            drive(r, en, fl, cs, c, rsd, rtd, se, rs, rt, rd);
            if (r) begin
                m = '{8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 0, 0};
            end else if (en && fl) begin
                m = '{8'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, m.nb, m.nf + 1};
            end else if (en && !cs) begin
                m = '{8'h00, rsd, rtd, se, rs, rt, rd, 1'b0, m.nb + 1, m.nf};
            end else if (en) begin
                m = '{c, rsd, rtd, se, rs, rt, rd, 1'b1, m.nb, m.nf};
            end
            tick();
            check($sformatf("rnd%0d_ctrl", i),  64'(ctrl_out()),      64'(m.ctrl));
            check($sformatf("rnd%0d_data", i),
                  {bus.RSdata_o, bus.RTdata_o}, {m.rsd, m.rtd});
            check($sformatf("rnd%0d_se", i),    64'(bus.SignExt_o),   64'(m.se));
            check($sformatf("rnd%0d_spec", i),
                  64'({bus.Rs_o, bus.Rt_o, bus.Rd_o}), 64'({m.rs, m.rt, m.rd}));
            check($sformatf("rnd%0d_valid", i), 64'(bus.Valid_o),     64'(m.vld));
            check($sformatf("rnd%0d_bcnt", i),  64'(bus.BubbleCnt_o), 64'(sat(m.nb)));
            check($sformatf("rnd%0d_fcnt", i),  64'(bus.FlushCnt_o),  64'(sat(m.nf)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
